// File: rtl/ac_unit_pkg.sv
// Shared op-code and FSM encodings for the AC/E register stage.
package ac_unit_pkg;

    localparam int AC_W = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_CLA = 4'h1;
    localparam logic [3:0] OP_CLE = 4'h2;
    localparam logic [3:0] OP_CMA = 4'h3;
    localparam logic [3:0] OP_CME = 4'h4;
    localparam logic [3:0] OP_CIR = 4'h5;
    localparam logic [3:0] OP_CIL = 4'h6;
    localparam logic [3:0] OP_INC = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_ADD = 4'h9;
    localparam logic [3:0] OP_LDA = 4'hA;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [3:0]      code;
        logic [AC_W-1:0] data;
    } op_req_t;

    // Codes 4'hB..4'hF have no meaning and retire as illegal.
    function automatic logic op_is_legal(input logic [3:0] code);
        return code <= OP_LDA;
    endfunction

endpackage

// File: rtl/sixteenbitadder.sv
// 16-bit ripple-carry adder built from a chain of full-adder bit slices.
module sixteenbitadder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [16:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 16; i++) begin : g_bit
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[16];

endmodule

// File: rtl/ac_e_register_unit.sv
// Accumulator + extend flip-flop stage: 3-cycle IDLE/EXEC/DONE handshake,
// ADD and INC routed through the shared ripple adder.
module ac_e_register_unit
    import ac_unit_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter logic [DATA_W-1:0] AC_RST = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic [DATA_W-1:0] op_data,
    output logic [DATA_W-1:0] ac_out,
    output logic              e_out,
    output logic              done,
    output logic              illegal_op,
    output logic              ac_zero,
    output logic              ac_neg
);

    if (DATA_W != AC_W) begin : g_bad_width
        $error("ac_e_register_unit: DATA_W must be 16 (adder is fixed width)");
    end

    logic [1:0]        state;
    op_req_t           op_q;
    logic [DATA_W-1:0] ac;
    logic              e;
    logic [DATA_W-1:0] ac_nxt;
    logic              e_nxt;
    logic [AC_W-1:0]   add_b;
    logic [AC_W-1:0]   add_sum;
    logic              add_cout;

    // Only ADD and INC present a non-zero second operand to the adder.
    always_comb begin
        add_b = '0;
        if (op_q.code == OP_ADD)      add_b = op_q.data;
        else if (op_q.code == OP_INC) add_b = 16'h0001;
    end

    sixteenbitadder u_adder (
        .a    (ac),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        ac_nxt = ac;
        e_nxt  = e;
        case (op_q.code)
            OP_CLA: ac_nxt = '0;
            OP_CLE: e_nxt  = 1'b0;
            OP_CMA: ac_nxt = ~ac;
            OP_CME: e_nxt  = ~e;
            OP_CIR: begin
                ac_nxt = {e, ac[DATA_W-1:1]};
                e_nxt  = ac[0];
            end
            OP_CIL: begin
                ac_nxt = {ac[DATA_W-2:0], e};
                e_nxt  = ac[DATA_W-1];
            end
            OP_INC: ac_nxt = add_sum;
            OP_AND: ac_nxt = ac & op_q.data;
            OP_ADD: begin
                ac_nxt = add_sum;
                e_nxt  = add_cout;
            end
            OP_LDA: ac_nxt = op_q.data;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= '0;
            ac    <= AC_RST;
            e     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (op_valid) begin
                    op_q.code <= op_code;
                    op_q.data <= op_data;
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    ac    <= ac_nxt;
                    e     <= e_nxt;
                    state <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign op_ready   = (state == ST_IDLE);
    assign done       = (state == ST_DONE);
    assign illegal_op = done & ~op_is_legal(op_q.code);
    assign ac_out     = ac;
    assign e_out      = e;
    assign ac_zero    = (ac == '0);
    assign ac_neg     = ac[DATA_W-1];

endmodule
